// File: rtl/seg7_scan_driver.sv
// Multiplexed seven-segment scan driver.
// Double-buffered BCD/hex value, one digit driven at a time for SCAN_DIV
// cycles, with leading-zero ripple blanking, lamp test and blanking.
// All outputs are registered from the previous cycle's index/active/controls.
module seg7_scan_driver #(
   parameter int DIGITS   = 4,
   parameter int SCAN_DIV = 1000,
   parameter int HEX_MODE = 0
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic [4*DIGITS-1:0]   data,
   input  logic                  load,
   input  logic                  LT,
   input  logic                  RBI,
   input  logic                  BI,
   output logic [6:0]            display,
   output logic [DIGITS-1:0]     dig_sel,
   output logic                  frame_done
);

   localparam int PW = $clog2(SCAN_DIV);
   localparam int IW = $clog2(DIGITS);
   localparam logic [PW-1:0] PRESC_LAST = PW'(SCAN_DIV - 1);
   localparam logic [IW-1:0] INDEX_LAST = IW'(DIGITS - 1);

   logic [PW-1:0]         r_presc;
   logic [IW-1:0]         r_index;
   logic [4*DIGITS-1:0]   r_staging;
   logic [4*DIGITS-1:0]   r_active;
   logic                  r_pending;
   logic                  r_wrap;

   logic                  w_presc_last;
   logic                  w_boundary;
   logic [DIGITS-1:0]     w_ripple;
   logic [3:0]            w_digit;
   logic                  w_blank;
   logic [DIGITS-1:0]     w_onehot;

   // Glyph lookup; codes 10-15 follow either the 7448 legacy set or hex letters.
   function automatic logic [6:0] glyph(input logic [3:0] v);
      logic [6:0] g;
      case (v)
         4'd0:  g = 7'h7E;
         4'd1:  g = 7'h30;
         4'd2:  g = 7'h6D;
         4'd3:  g = 7'h79;
         4'd4:  g = 7'h33;
         4'd5:  g = 7'h5B;
         4'd6:  g = 7'h5F;
         4'd7:  g = 7'h70;
         4'd8:  g = 7'h7F;
         4'd9:  g = 7'h73;
         4'd10: g = (HEX_MODE != 0) ? 7'h77 : 7'h0D;
         4'd11: g = (HEX_MODE != 0) ? 7'h1F : 7'h19;
         4'd12: g = (HEX_MODE != 0) ? 7'h4E : 7'h23;
         4'd13: g = (HEX_MODE != 0) ? 7'h3D : 7'h4B;
         4'd14: g = (HEX_MODE != 0) ? 7'h4F : 7'h0F;
         default: g = (HEX_MODE != 0) ? 7'h47 : 7'h00;
      endcase
      return g;
   endfunction

   assign w_presc_last = (r_presc == PRESC_LAST);
   assign w_boundary   = w_presc_last && (r_index == INDEX_LAST);
   assign w_onehot     = DIGITS'(1) << r_index;

   // Prescaler and digit index: advance to the next digit after each dwell.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_presc <= '0;
         r_index <= '0;
      end else if (w_presc_last) begin
         r_presc <= '0;
         r_index <= (r_index == INDEX_LAST) ? '0 : r_index + IW'(1);
      end else begin
         r_presc <= r_presc + PW'(1);
      end
   end

   // Double buffer: a load always wins over the frame-boundary copy, so a load
   // landing on the boundary waits for the following frame.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_staging <= '0;
         r_active  <= '0;
         r_pending <= 1'b0;
      end else if (load) begin
         r_staging <= data;
         r_pending <= 1'b1;
      end else if (w_boundary && r_pending) begin
         r_active  <= r_staging;
         r_pending <= 1'b0;
      end
   end

   // Ripple blanking: a digit blanks when it and every more significant digit are zero.
   always_comb begin
      logic v_zero;
      w_ripple = '0;
      v_zero   = 1'b1;
      for (int i = DIGITS - 1; i >= 0; i--) begin
         v_zero      = v_zero && (r_active[4*i +: 4] == 4'd0);
         w_ripple[i] = RBI && v_zero && (i != 0);
      end
   end

   // Select the value and blank flag of the digit currently being scanned.
   always_comb begin
      w_digit = '0;
      w_blank = 1'b0;
      for (int i = 0; i < DIGITS; i++) begin
         if (r_index == IW'(i)) begin
            w_digit = r_active[4*i +: 4];
            w_blank = w_ripple[i];
         end
      end
   end

   // Registered segment and digit-enable outputs with BI > LT > ripple > glyph priority.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         display <= '0;
         dig_sel <= '0;
      end else if (BI) begin
         display <= '0;
         dig_sel <= '0;
      end else begin
         dig_sel <= w_onehot;
         if (LT)
            display <= 7'h7F;
         else if (w_blank)
            display <= '0;
         else
            display <= glyph(w_digit);
      end
   end

   // Frame pulse is delayed one stage so it lines up with dig_sel returning to digit 0.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_wrap     <= 1'b0;
         frame_done <= 1'b0;
      end else begin
         r_wrap     <= w_boundary;
         frame_done <= r_wrap;
      end
   end

endmodule

// File: doc/seg7_scan_driver.md
# seg7_scan_driver

Multiplexed N-digit seven-segment display driver, successor to the single-digit 7448-style BCD decoder. Holds a double-buffered packed BCD/hex value, scans one digit at a time with a programmable dwell, and adds multi-digit ripple (leading-zero) blanking, lamp test, blanking and a hex-glyph mode. Sits between the charger's time/coin counters and the physical display pins.

## Interface
- DIGITS, 4: number of digits scanned (≥2).
- SCAN_DIV, 1000: clock cycles each digit is driven (≥2).
- HEX_MODE, 0: 0 = 7448 legacy glyphs for codes 10–15; 1 = hex glyphs A b C d E F.
- clk  input  1  system clock, all state on rising edge.
- reset  input  1  asynchronous, active-high; clears all state immediately.
- data  input  4*DIGITS  packed value; digit i = data[4i+3:4i], digit 0 least significant.
- load  input  1  single-cycle strobe; captures data into staging register.
- LT  input  1  lamp test, active-high.
- RBI  input  1  ripple-blanking enable (leading-zero suppression), active-high.
- BI  input  1  blanking, active-high.
- display  output  7  segments, active-high; display[6..0] = a,b,c,d,e,f,g.
- dig_sel  output  DIGITS  one-hot digit enable, active-high.
- frame_done  output  1  one-cycle pulse when the last digit's dwell ends.

## Operation
- Registers: prescaler (0..SCAN_DIV-1), digit index (0..DIGITS-1), staging, active, pending flag.
- load=1: staging ← data, pending ← 1. Staging is never shown directly.
- Frame boundary (prescaler = SCAN_DIV-1 and index = DIGITS-1): if pending, active ← staging, pending ← 0; frame_done ← 1. load in the same cycle as the boundary: staging takes the new data, pending stays 1, copy happens at the next boundary.
- Prescaler = SCAN_DIV-1: prescaler ← 0, index ← index+1, wrapping DIGITS-1 → 0; otherwise prescaler+1.
- Ripple blank of digit i (computed on active): RBI=1, digit value 0, and every digit j>i also 0. Digit 0 is never ripple-blanked (value 0 with RBI shows "0").
- Output priority per scanned digit: BI=1 → display=0, dig_sel=0; else LT=1 → display=7'h7F, dig_sel one-hot; else ripple-blanked → display=0, dig_sel one-hot; else glyph.
- Glyphs 0–9: 7E,30,6D,79,33,5B,5F,70,7F,73.
- HEX_MODE=0, 10–15: 0D,19,23,4B,0F,00.
- HEX_MODE=1, 10–15: 77,1F,4E,3D,4F,47.
- LT, RBI, BI are level inputs sampled every cycle, not latched.

## Timing
- All outputs registered; reflect index/active/controls of the previous cycle.
- Reset: display=0, dig_sel=0, frame_done=0, prescaler=0, index=0, staging=active=0, pending=0.
- First clock after reset release: dig_sel=1 (digit 0), display=7E (active=0, RBI-independent for digit 0).
- Each digit enabled for exactly SCAN_DIV cycles; frame period DIGITS*SCAN_DIV cycles.
- load to visible: active updates at the next frame boundary, visible on display one cycle later when digit 0 is next driven.
- frame_done high one cycle, coincident with dig_sel switching from digit DIGITS-1 to 0.
- Control change (LT/RBI/BI) visible on the next cycle, mid-dwell included.
- Reset asserted mid-frame: outputs clear asynchronously; pending load discarded.

## Test plan
- DIGITS=4, SCAN_DIV=4, HEX_MODE=0: reset, load data=16'h9876, controls 0 → after one frame boundary, digits 0..3 show 5F,70,7F,73, each for 4 cycles, dig_sel 0001→0010→0100→1000, frame_done every 16 cycles.
- Load 16'h0040, RBI=1 → digit 3 and 2 blank (display=0, dig_sel still scanning), digit 1 = 33, digit 0 = 7E; load 16'h0000 → only digit 0 lit with 7E.
- LT=1 mid-dwell → next cycle display=7F on every digit; BI=1 together with LT → display=0, dig_sel=0.
- Codes 10–15 on all digits, HEX_MODE=0 → 0D,19,23,4B,0F,00; HEX_MODE=1 → 77,1F,4E,3D,4F,47.
- Two loads within one frame (16'h1111 then 16'h2222) → only 2222 becomes visible, no frame shows a mix of both values; load on the boundary cycle defers to the following frame.
- Reset pulsed mid-frame → display=0, dig_sel=0 immediately; after release digit 0 shows 7E, prior staging not displayed.
